// File: rtl/vga_timing_recovery_if.sv
// Video timing bundle between a sync source and the timing recovery block.
// The source drives pix_en/h_sync/v_sync/display; they are only looked at on clk edges with pix_en=1.
interface vga_timing_recovery_if #(
    parameter int W = 16
);
    logic         pix_en;
    logic         h_sync;
    logic         v_sync;
    logic         display;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] line_len;
    logic [W-1:0] frame_lines;
    logic         active;
    logic         locked;
    logic         err;
    logic [1:0]   state;

    modport master (
        output pix_en, h_sync, v_sync, display,
        input  x, y, line_len, frame_lines, active, locked, err, state
    );

    modport slave (
        input  pix_en, h_sync, v_sync, display,
        output x, y, line_len, frame_lines, active, locked, err, state
    );
endinterface

// File: rtl/vga_timing_recovery.sv
// Recovers pixel/line coordinates from VGA sync edges, measures line and frame
// length, and runs a lock FSM that qualifies the incoming timing.
module vga_timing_recovery #(
    parameter int LOCK_FRAMES = 2,
    parameter int MAX_LINE    = 1024,
    parameter int W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_timing_recovery_if.slave  bus
);
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [W-1:0] ONES      = '1;
    localparam logic [W-1:0] TIMEOUT_X = W'(MAX_LINE - 2);
    localparam logic [3:0]   LOCK_N    = 4'(LOCK_FRAMES);

    state_t       state_q, state_d;
    logic         h_prev_q, h_prev_d, v_prev_q, v_prev_d;
    logic [W-1:0] x_q, x_d, y_q, y_d;
    logic [W-1:0] line_len_q, line_len_d, frame_q, frame_d;
    logic [W-1:0] ref_line_q, ref_line_d, ref_frame_q, ref_frame_d;
    logic         ref_valid_q, ref_valid_d;
    logic [3:0]   match_q, match_d;
    logic         locked_q, locked_d, err_q, err_d, active_q, active_d;

    logic         hr, vr;
    logic [W-1:0] line_meas, frame_meas;
    logic         line_bad, frame_bad, timeout, fail;

    assign hr         = bus.h_sync & ~h_prev_q;
    assign vr         = bus.v_sync & ~v_prev_q;
    assign line_meas  = x_q + 1'b1;
    assign frame_meas = y_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        h_prev_d    = h_prev_q;
        v_prev_d    = v_prev_q;
        x_d         = x_q;
        y_d         = y_q;
        line_len_d  = line_len_q;
        frame_d     = frame_q;
        ref_line_d  = ref_line_q;
        ref_frame_d = ref_frame_q;
        ref_valid_d = ref_valid_q;
        match_d     = match_q;
        locked_d    = locked_q;
        active_d    = active_q;
        err_d       = 1'b0;
        line_bad    = hr && ref_valid_q && (line_meas != ref_line_q);
        frame_bad   = vr && (frame_meas != ref_frame_q);
        timeout     = !hr && (x_q == TIMEOUT_X);
        fail        = 1'b0;

        if (bus.pix_en) begin
            h_prev_d = bus.h_sync;
            v_prev_d = bus.v_sync;

            if (hr) begin
                line_len_d = line_meas;
                x_d        = '0;
            end else begin
                x_d = (x_q == ONES) ? x_q : line_meas;
            end

            if (vr) begin
                frame_d = frame_meas;
                y_d     = '0;
            end else if (hr) begin
                y_d = (y_q == ONES) ? y_q : frame_meas;
            end

            case (state_q)
                SEARCH: begin
                    if (vr) begin
                        state_d     = MEASURE;
                        ref_valid_d = 1'b0;
                    end
                end
                MEASURE: begin
                    if (line_bad) begin
                        fail = 1'b1;
                    end else begin
                        if (hr && !ref_valid_q) begin
                            ref_line_d  = line_meas;
                            ref_valid_d = 1'b1;
                        end
                        // A frame start with no stored line restarts the measurement.
                        if (vr) begin
                            if (ref_valid_q) begin
                                ref_frame_d = frame_meas;
                                match_d     = 4'd0;
                                state_d     = VERIFY;
                            end else begin
                                ref_valid_d = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    if (line_bad || frame_bad) begin
                        fail = 1'b1;
                    end else if (vr && state_q == VERIFY) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == LOCK_N) state_d = LOCKED;
                    end
                end
            endcase

            if (fail || timeout) begin
                err_d       = 1'b1;
                state_d     = SEARCH;
                ref_valid_d = 1'b0;
                match_d     = 4'd0;
            end

            locked_d = (state_d == LOCKED);
            active_d = bus.display & locked_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            h_prev_q    <= 1'b1;
            v_prev_q    <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            line_len_q  <= '0;
            frame_q     <= '0;
            ref_line_q  <= '0;
            ref_frame_q <= '0;
            ref_valid_q <= 1'b0;
            match_q     <= 4'd0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_prev_q    <= h_prev_d;
            v_prev_q    <= v_prev_d;
            x_q         <= x_d;
            y_q         <= y_d;
            line_len_q  <= line_len_d;
            frame_q     <= frame_d;
            ref_line_q  <= ref_line_d;
            ref_frame_q <= ref_frame_d;
            ref_valid_q <= ref_valid_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            active_q    <= active_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.line_len    = line_len_q;
    assign bus.frame_lines = frame_q;
    assign bus.active      = active_q;
    assign bus.locked      = locked_q;
    assign bus.err         = err_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_vga_timing_recovery.sv
// Randomised-gap video stream checked every cycle against a per-strobe
// behavioural model, plus literal checkpoints on lock, error and saturation.
module tb_vga_timing_recovery;
    localparam int W           = 12;
    localparam int LOCK_FRAMES = 2;
    localparam int MAX_LINE    = 1024;
    localparam int MAXV        = (1 << W) - 1;
    localparam int H_TOT       = 24;
    localparam int V_TOT       = 8;
    localparam int VS          = 3;
    localparam int S_SEARCH = 0, S_MEASURE = 1, S_VERIFY = 2, S_LOCKED = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_recovery_if #(.W(W)) bus ();

    vga_timing_recovery #(
        .LOCK_FRAMES(LOCK_FRAMES),
        .MAX_LINE   (MAX_LINE),
        .W          (W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    int err_x = -1;

    // Model: what each output must be after the next clock edge.
    int m_x, m_y, m_ll, m_fl, m_act, m_lock, m_err, m_state;
    int m_hp, m_vp, m_rl, m_rf, m_rv, m_good;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_ll = 0; m_fl = 0;
        m_act = 0; m_lock = 0; m_err = 0; m_state = S_SEARCH;
        m_hp = 1; m_vp = 1; m_rl = 0; m_rf = 0; m_rv = 0; m_good = 0;
    endtask

    task automatic model_tick(input int pe, input int h, input int v, input int d);
        int hr, vr, lm, fm, bad, tmo, nrv;
        m_err = 0;
        if (pe != 0) begin
            hr = (h != 0 && m_hp == 0) ? 1 : 0;
            vr = (v != 0 && m_vp == 0) ? 1 : 0;
            m_hp = h; m_vp = v;
            lm  = (m_x + 1) & MAXV;
            fm  = (m_y + 1) & MAXV;
            tmo = (hr == 0 && m_x + 1 == MAX_LINE - 1) ? 1 : 0;
            bad = 0;
            if (hr != 0 && m_rv != 0 && lm != m_rl) bad = 1;
            if (m_state >= S_VERIFY && vr != 0 && fm != m_rf) bad = 1;
            if (bad == 0) begin
                if (m_state == S_SEARCH && vr != 0) m_state = S_MEASURE;
                else if (m_state == S_MEASURE) begin
                    nrv = m_rv;
                    if (hr != 0 && m_rv == 0) begin m_rl = lm; nrv = 1; end
                    if (vr != 0) begin
                        if (m_rv != 0) begin m_rf = fm; m_good = 0; m_state = S_VERIFY; end
                        else nrv = 0;
                    end
                    m_rv = nrv;
                end else if (m_state == S_VERIFY && vr != 0) begin
                    m_good++;
                    if (m_good == LOCK_FRAMES) m_state = S_LOCKED;
                end
            end
            if (hr != 0) m_ll = lm;
            if (vr != 0) m_fl = fm;
            m_y = (vr != 0) ? 0 : (hr != 0) ? ((m_y + 1 > MAXV) ? MAXV : m_y + 1) : m_y;
            m_x = (hr != 0) ? 0 : ((m_x + 1 > MAXV) ? MAXV : m_x + 1);
            if (bad != 0 || tmo != 0) begin
                m_err = 1; m_state = S_SEARCH; m_rv = 0; m_good = 0;
            end
            m_lock = (m_state == S_LOCKED) ? 1 : 0;
            m_act  = (d != 0 && m_lock != 0) ? 1 : 0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("x", int'(bus.x), m_x);
        chk("y", int'(bus.y), m_y);
        chk("line_len", int'(bus.line_len), m_ll);
        chk("frame_lines", int'(bus.frame_lines), m_fl);
        chk("active", int'(bus.active), m_act);
        chk("locked", int'(bus.locked), m_lock);
        chk("err", int'(bus.err), m_err);
        chk("state", int'(bus.state), m_state);
        if (bus.err) begin
            err_seen++;
            err_x = int'(bus.x);
        end
    end

    task automatic drive(input logic pe, input logic h, input logic v, input logic d);
        @(negedge clk);
        rst = 1'b0;
        bus.pix_en = pe; bus.h_sync = h; bus.v_sync = v; bus.display = d;
        model_tick(int'(pe), int'(h), int'(v), int'(d));
        @(posedge clk);
        #2;
    endtask

    task automatic reset_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            bus.pix_en = 1'b1; bus.h_sync = 1'b1; bus.v_sync = 1'b1; bus.display = 1'b1;
            model_reset();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_px(input int px, input int py);
        logic h, v;
        h = (px < 2);
        v = (py < VS);
        drive(1'b1, h, v, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(1, 2))
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_lines(input int y0, input int y1, input int short_y);
        for (int ly = y0; ly < y1; ly++)
            for (int lx = 0; lx < ((ly == short_y) ? H_TOT - 1 : H_TOT); lx++)
                send_px(lx, ly);
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) send_lines(0, V_TOT, -1);
    endtask

    initial begin
        bus.pix_en = 1'b0; bus.h_sync = 1'b1; bus.v_sync = 1'b1; bus.display = 1'b0;
        model_reset();
        reset_clks(3);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_state", int'(bus.state), S_SEARCH);

        // Release with both syncs high: the first frame start is not an edge.
        frames(1);
        chk("noedge_state", int'(bus.state), S_SEARCH);
        chk("noedge_frame_lines", int'(bus.frame_lines), 0);
        chk("noedge_x", int'(bus.x), H_TOT - 1);
        frames(1);
        chk("first_vr_state", int'(bus.state), S_MEASURE);
        frames(1);
        chk("second_vr_state", int'(bus.state), S_VERIFY);
        frames(1);
        chk("third_vr_locked", int'(bus.locked), 0);
        frames(1);
        chk("fourth_vr_locked", int'(bus.locked), 1);
        chk("line_len", int'(bus.line_len), H_TOT);
        chk("frame_lines", int'(bus.frame_lines), V_TOT);
        chk("no_err_during_lock", err_seen, 0);

        // One short line breaks lock with a single err pulse.
        err_seen = 0;
        send_lines(0, V_TOT, 4);
        chk("short_err_pulses", err_seen, 1);
        chk("short_state", int'(bus.state), S_SEARCH);
        frames(3);
        chk("relock_pending", int'(bus.state), S_VERIFY);
        frames(1);
        chk("relock", int'(bus.locked), 1);

        // h_sync stall: timeout at MAX_LINE-1, then x saturates.
        err_seen = 0;
        for (int i = 0; i < 4200; i++) drive(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        chk("timeout_pulses", err_seen, 1);
        chk("timeout_x", err_x, MAX_LINE - 1);
        chk("timeout_locked", int'(bus.locked), 0);
        chk("x_saturated", int'(bus.x), MAXV);
        frames(4);
        chk("stall_relock", int'(bus.locked), 1);

        // Reset mid-frame while locked.
        send_lines(0, 3, -1);
        reset_clks(3);
        chk("midrst_x", int'(bus.x), 0);
        chk("midrst_y", int'(bus.y), 0);
        chk("midrst_line_len", int'(bus.line_len), 0);
        chk("midrst_frame_lines", int'(bus.frame_lines), 0);
        chk("midrst_active", int'(bus.active), 0);
        chk("midrst_err", int'(bus.err), 0);
        frames(LOCK_FRAMES + 2);
        chk("midrst_not_yet", int'(bus.locked), 0);
        frames(1);
        chk("midrst_relock", int'(bus.locked), 1);

        // Idle strobe gap with toggling syncs changes nothing.
        for (int lx = 0; lx < 10; lx++) send_px(lx, 0);
        for (int i = 0; i < 50; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("idle_x", int'(bus.x), 9);
        chk("idle_y", int'(bus.y), 0);
        chk("idle_line_len", int'(bus.line_len), H_TOT);
        chk("idle_state", int'(bus.state), S_LOCKED);
        for (int lx = 10; lx < H_TOT; lx++) send_px(lx, 0);
        send_lines(1, V_TOT, -1);
        err_seen = 0;
        frames(1);
        chk("final_locked", int'(bus.locked), 1);
        chk("final_no_err", err_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
